// File: rtl/dbus_sram_responder_pkg.sv
// Shared bus types and responder constants for the CPU data-bus SRAM responder.
// The responder state enum and latency bound are reused by the instruction-bus responder.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } resp_state_e;

  localparam int unsigned LatencyMax = 7;
  localparam int unsigned CntBits    = 3;

endpackage

// File: rtl/dbus_sram_bank.sv
// Word-organised SRAM with per-byte write enables; a write returns the merged new word
// on the same edge (write-first).
module dbus_sram_bank #(
  parameter int unsigned AddrBits = 10
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [AddrBits-1:0] addr_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o
);

  logic [31:0] mem [0:(1 << AddrBits) - 1];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          rdata_o[8*i +: 8]     <= wdata_i[8*i +: 8];
        end else begin
          rdata_o[8*i +: 8]     <= mem[addr_i][8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus slave: accepts one request at a time, performs byte-strobed SRAM access at accept,
// and answers with data_ok after a fixed LATENCY.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  input  logic        hold,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  if (LATENCY < 1 || LATENCY > LatencyMax) begin : g_bad_latency
    $error("dbus_sram_responder: LATENCY must be within 1..%0d", LatencyMax);
  end

  localparam logic [CntBits-1:0] CntInit = CntBits'((LATENCY >= 2) ? LATENCY - 2 : 0);

  resp_state_e        state_q;
  logic [CntBits-1:0] cnt_q;
  logic               write_q;
  logic [31:0]        rdata;
  logic               addr_ok;
  logic               accept;
  logic               unused_req;

  // addr_ok depends only on state and hold, never on the request itself.
  assign addr_ok = (state_q == StIdle) && !hold;
  assign accept  = dreq.valid && addr_ok;

  // Size, upper address bits and byte offset play no part in the access.
  assign unused_req = ^{dreq.size, dreq.addr[31:ADDR_BITS+2], dreq.addr[1:0]};

  dbus_sram_bank #(
    .AddrBits (ADDR_BITS)
  ) u_bank (
    .clk_i   (clk),
    .en_i    (accept),
    .addr_i  (dreq.addr[ADDR_BITS+1:2]),
    .be_i    (dreq.strobe),
    .wdata_i (dreq.data),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            write_q <= |dreq.strobe;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - CntBits'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (write_q) begin
            wr_count <= wr_count + 32'd1;
          end else begin
            rd_count <= rd_count + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The bank output register holds the word sampled at accept until the next accept,
  // which cannot happen before RESP has passed.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = addr_ok;
    dresp.data_ok = (state_q == StResp);
    dresp.data    = (state_q == StResp && !write_q) ? rdata : 32'd0;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench for dbus_sram_responder: three instances at LATENCY 1, 4 and 3.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int NDut = 3;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] due;
  } exp_t;

  logic        clk = 1'b0;
  logic [31:0] cyc = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  dbus_req_t   dreq     [NDut];
  dbus_resp_t  dresp    [NDut];
  logic        hold     [NDut];
  logic        resetn   [NDut];
  logic [31:0] rd_count [NDut];
  logic [31:0] wr_count [NDut];
  exp_t        exp_q    [NDut][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 3;
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp_v);
    end
  endfunction

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    dbus_sram_responder #(
      .ADDR_BITS (10),
      .LATENCY   ((g == 0) ? 1 : (g == 1) ? 4 : 3)
    ) u_dut (
      .clk      (clk),
      .resetn   (resetn[g]),
      .dreq     (dreq[g]),
      .dresp    (dresp[g]),
      .hold     (hold[g]),
      .rd_count (rd_count[g]),
      .wr_count (wr_count[g])
    );

    always @(negedge clk) begin : monitor
      exp_t e;
      if (resetn[g] === 1'b1) begin
        if (dresp[g].data_ok === 1'b1) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d unexpected_data_ok: got data_ok=1 at cycle %0d required 0",
                     g, cyc);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("dut%0d resp_data", g), dresp[g].data, e.data);
            check($sformatf("dut%0d resp_cycle", g), cyc, e.due);
            check($sformatf("dut%0d addr_ok_with_data_ok", g), {31'b0, dresp[g].addr_ok}, 0);
          end
        end else if (exp_q[g].size() != 0 && cyc > exp_q[g][0].due) begin
          e = exp_q[g].pop_front();
          n_checks++;
          n_errors++;
          $display("FAIL dut%0d missing_data_ok: got none by cycle %0d required at cycle %0d",
                   g, cyc, e.due);
        end
      end
    end
  end

  // Called aligned to posedge+1; returns aligned to posedge+1 after the accept edge.
  task automatic txn(input int k, input logic [31:0] addr, input logic [3:0] strobe,
                     input logic [31:0] data, input logic [31:0] exp_data,
                     input bit keep_valid, output int waited);
    exp_t e;
    bit   done;
    done   = 1'b0;
    waited = 0;
    dreq[k].valid  = 1'b1;
    dreq[k].addr   = addr;
    dreq[k].size   = MSIZE4;
    dreq[k].strobe = strobe;
    dreq[k].data   = data;
    while (!done && waited < 40) begin
      @(negedge clk);
      if (dresp[k].addr_ok === 1'b1) begin
        e.data = exp_data;
        e.due  = cyc + 32'(lat(k));
        exp_q[k].push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) waited++;
    end
    if (!keep_valid) dreq[k].valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL dut%0d accept_timeout: got no addr_ok in 40 cycles required an accept", k);
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("dut%0d drain", k), exp_q[k].size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    for (int k = 0; k < NDut; k++) begin
      resetn[k] = 1'b0;
      hold[k]   = 1'b0;
      dreq[k]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("dut%0d reset_addr_ok", k), {31'b0, dresp[k].addr_ok}, 1);
      check($sformatf("dut%0d reset_data_ok", k), {31'b0, dresp[k].data_ok}, 0);
      check($sformatf("dut%0d reset_data", k), dresp[k].data, 0);
      check($sformatf("dut%0d reset_rd_count", k), rd_count[k], 0);
      check($sformatf("dut%0d reset_wr_count", k), wr_count[k], 0);
      resetn[k] = 1'b1;
    end
    @(posedge clk);
    #1;

    // LATENCY=1: full write, read, byte-strobe write, read-back, aliasing.
    txn(0, 32'h0000_0040, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, w);
    wait_idle(0);
    txn(0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    wait_idle(0);
    check("dut0 rd_count_after_read", rd_count[0], 1);
    txn(0, 32'h0000_0041, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0, w);
    wait_idle(0);
    txn(0, 32'h0000_0040, 4'h0, 32'h0, 32'hDEAD_AAEF, 1'b0, w);
    wait_idle(0);
    check("dut0 wr_count_after_strobe", wr_count[0], 2);
    txn(0, 32'h0000_1004, 4'hF, 32'h1234_5678, 32'h0, 1'b0, w);
    txn(0, 32'h0000_0004, 4'h0, 32'h0, 32'h1234_5678, 1'b0, w);
    txn(0, 32'h0000_0006, 4'b1100, 32'hCAFE_0000, 32'h0, 1'b0, w);
    txn(0, 32'h8000_0007, 4'h0, 32'h0, 32'hCAFE_5678, 1'b0, w);
    wait_idle(0);
    check("dut0 rd_count_final", rd_count[0], 4);
    check("dut0 wr_count_final", wr_count[0], 4);

    // LATENCY=4: valid held high across the transaction, then hold backpressure.
    txn(1, 32'h0000_0100, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0, w);
    wait_idle(1);
    txn(1, 32'h0000_0100, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b1, w);
    check("dut1 addr_ok_in_wait", {31'b0, dresp[1].addr_ok}, 0);
    wait_idle(1);
    check("dut1 rd_count_single", rd_count[1], 1);
    check("dut1 addr_ok_after_resp", {31'b0, dresp[1].addr_ok}, 1);
    txn(1, 32'h0000_0100, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, w);
    check("dut1 reaccept_wait", w, 0);
    wait_idle(1);
    check("dut1 rd_count_two", rd_count[1], 2);

    hold[1] = 1'b1;
    dreq[1].valid  = 1'b1;
    dreq[1].addr   = 32'h0000_0100;
    dreq[1].strobe = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("dut1 addr_ok_hold", {31'b0, dresp[1].addr_ok}, 0);
      @(posedge clk);
      #1;
    end
    hold[1] = 1'b0;
    txn(1, 32'h0000_0100, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0, w);
    check("dut1 accept_after_hold", w, 0);
    hold[1] = 1'b1;
    wait_idle(1);
    hold[1] = 1'b0;
    check("dut1 rd_count_final", rd_count[1], 3);
    check("dut1 wr_count_final", wr_count[1], 1);

    // LATENCY=3: reset during WAIT after a committed write.
    txn(2, 32'h0000_0200, 4'hF, 32'h5A5A_A5A5, 32'h0, 1'b0, w);
    resetn[2] = 1'b0;
    exp_q[2].delete();
    #1;
    check("dut2 rd_count_in_reset", rd_count[2], 0);
    check("dut2 wr_count_in_reset", wr_count[2], 0);
    repeat (2) @(posedge clk);
    #1;
    resetn[2] = 1'b1;
    #1;
    check("dut2 addr_ok_after_reset", {31'b0, dresp[2].addr_ok}, 1);
    repeat (5) @(posedge clk);
    #1;
    check("dut2 wr_count_no_resp", wr_count[2], 0);
    txn(2, 32'h0000_0200, 4'h0, 32'h0, 32'h5A5A_A5A5, 1'b0, w);
    wait_idle(2);
    check("dut2 rd_count_final", rd_count[2], 1);
    check("dut2 wr_count_final", wr_count[2], 0);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDut; k++) begin
      check($sformatf("dut%0d scoreboard_empty", k), exp_q[k].size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Data-bus slave that terminates the `dbus_req_t`/`dbus_resp_t` handshake driven by the CPU memory stage. It accepts one request at a time through `addr_ok` and performs byte-strobed writes into a word-organised on-chip SRAM. It returns read data or write completion on `data_ok` after a fixed, parameterised latency. It serves as the simulation and FPGA stand-in for the data cache/AXI bridge, and exercises every initiator state: STORE, STOREWAIT, LOAD and LOADWAIT.

## Interface
- `ADDR_BITS`, default 10: number of word-index bits. SRAM holds 2^ADDR_BITS 32-bit words.
- `LATENCY`, default 1: cycles from the accept edge to `data_ok`. Legal range is 1..7; elaboration fails outside that range.
- `clk`: input, 1 bit. Clock; all state updates on the rising edge.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `dreq`: input, `dbus_req_t`. Request from the initiator, with fields `valid`, `addr`, `size`, `strobe` and `data`.
- `dresp`: output, `dbus_resp_t`. Response to the initiator, with fields `addr_ok`, `data_ok` and `data`.
- `hold`: input, 1 bit. Backpressure injection; while high, `addr_ok` is forced to 0.
- `rd_count`: output, 32 bits. Number of completed reads; wraps modulo 2^32.
- `wr_count`: output, 32 bits. Number of completed writes; wraps modulo 2^32.

## Operation
- **Request decode.**
  - `strobe == 0` means a read; `strobe != 0` means a write.
  - `size` is informational only. The responder performs no alignment check, because the initiator has already raised AdEL/AdES.
- **Addressing.**
  - Word index = `addr[ADDR_BITS+1:2]`.
  - Upper address bits are ignored, so addresses alias and wrap modulo 2^(ADDR_BITS+2).
  - `addr[1:0]` are ignored.
- **Read data.** A read returns the full aligned word; the initiator performs byte/halfword extraction.
- **Write data.** A write updates byte lane i (bits 8i+7:8i) of the word only where `strobe[i]` = 1. Unselected lanes are untouched.
- **State machine**, one transaction in flight:
  - **IDLE:** `addr_ok = !hold`, combinational, not gated by `valid`. Accept = `dreq.valid && addr_ok`. On an accept edge:
    - latch the request;
    - perform any write into the SRAM;
    - sample the read word;
    - go to RESP if LATENCY = 1; otherwise go to WAIT with `cnt` = LATENCY−2.
  - **WAIT:** `addr_ok` = 0. Decrement `cnt`; when `cnt` = 0, go to RESP.
  - **RESP:** `data_ok` = 1 for exactly this cycle and `addr_ok` = 0. Go to IDLE. `rd_count` or `wr_count` increments on this edge.
- **Response data.**
  - For a read, `dresp.data` = the word sampled at accept, so a read-after-write in back-to-back transactions returns the written value.
  - For a write, `dresp.data` = 0.
  - Outside RESP, `dresp.data` = 0.
- **Ignored requests.** A `valid` held high during WAIT or RESP is ignored; it is not a new request.
- **Early withdrawal.** An initiator that drops `valid` after accept does not cancel the transaction; `data_ok` still fires.

## Timing
- **Reset values:** state IDLE, `cnt` = 0, `addr_ok` = 1 if `hold` = 0, `data_ok` = 0, `data` = 0, `rd_count` = `wr_count` = 0.
- **SRAM contents** are not reset.
- **Reset mid-transaction:** the pending transaction is dropped and no `data_ok` follows. A write already committed at the accept edge stays committed.
- **Latency:** accept at edge T gives `data_ok` high in the cycle after edge T+LATENCY−1. Minimum latency is 1 cycle; `addr_ok` and `data_ok` are never high in the same cycle.
- **Throughput:** the earliest next accept is at the cycle after RESP, so the peak rate is one transaction per LATENCY+1 cycles.
- **Hold:**
  - `hold` rising in IDLE blocks accept that cycle.
  - `hold` during WAIT or RESP has no effect on the in-flight transaction.
- **Outputs:** `data_ok` and `data` are registered (state-decoded). `addr_ok` is combinational from state and `hold` only, with no path from `dreq`.

## Structure
- `dbus_req_t`, `dbus_resp_t` and `msize_t` come from the existing common header; they are not redefined here.
- The responder state enum (IDLE, WAIT, RESP) and the LATENCY bound constant belong in the mycpu shared package for reuse by the instruction-bus responder.
- One sub-module, `dbus_sram_bank`:
  - 2^ADDR_BITS × 32 array;
  - four byte-write-enables;
  - synchronous write and synchronous read on the same edge, read-before-write forbidden (returns new data).
- Top level holds the FSM, latency counter, response register and the two counters.

## Test plan
- **LATENCY=1 read.** Preload word 0x10 = 0xDEADBEEF; read addr 0x40 -> `addr_ok` in cycle 0, `data_ok` with `data` = 0xDEADBEEF in cycle 1, `rd_count` = 1.
- **Byte-strobe write then read.** Word 0x10 = 0xDEADBEEF; write addr 0x41, strobe 0b0010, data 0x0000AA00 -> `data_ok` with `data` = 0. Following read of 0x40 returns 0xDEADAAEF; `wr_count` = 1.
- **LATENCY=4 with valid held high after accept.** `data_ok` arrives exactly 4 cycles after accept; only one transaction is counted; the second accept occurs only after RESP.
- **Hold asserted 3 cycles with valid high.** `addr_ok` = 0 for those 3 cycles; accept occurs on the first cycle `hold` = 0; latency is unchanged.
- **Aliasing with ADDR_BITS=10.** Write 0x12345678 to addr 0x1004, then read addr 0x0004 -> 0x12345678.
- **resetn pulsed low during WAIT (LATENCY=3).** No `data_ok`; counters read 0; `addr_ok` = 1 immediately after deassertion; next read returns correct data.
